// File: rtl/clock_enable_pkg.sv
// Shared constants and types for the clock-enable generator and its channels.
// Holds the default channel count, counter width and reset divisor.
package clock_enable_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 50;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // Width of a channel index: at least one bit, even for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_enable_channel.sv
// One divider channel: down-counter, shadowed divisor and registered tick/square outputs.
// Latency: outputs registered, tick on the D-th enabled edge; no backpressure, strobes act immediately.
module clock_enable_channel #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             resync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_CNT = (DEFAULT_DIV <= 1) ? '0 : CNT_W'(DEFAULT_DIV - 1);

  // A divisor of zero behaves as one, so both reload to a count of zero.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             reload;
  logic             apply;
  logic [CNT_W-1:0] div_next;

  always_comb begin
    reload   = en_i && (cnt_q == '0);
    // Shadow moves over only on a period boundary or a resync; a same-cycle
    // write lands in the shadow afterwards and stays pending.
    apply    = pending_q && (resync_i || reload);
    div_next = apply ? shadow_q : active_q;

    active_d  = div_next;
    shadow_d  = wr_i ? div_i : shadow_q;
    pending_d = wr_i || (pending_q && !apply);

    cnt_d  = cnt_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (resync_i) begin
      cnt_d = reload_val(div_next);
      clk_d = 1'b0;
    end else if (!en_i) begin
      cnt_d = reload_val(active_q);
    end else if (reload) begin
      cnt_d  = reload_val(div_next);
      tick_d = 1'b1;
      clk_d  = ~clk_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= RST_CNT;
      active_q  <= RST_DIV;
      shadow_q  <= RST_DIV;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_o     = clk_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: divisor write decode and resync fan-out to NUM_CH channels.
// Latency: one cycle from a write to pending; no backpressure, out-of-range writes are dropped.
module clock_enable_gen
  import clock_enable_pkg::*;
#(
  parameter int  NUM_CH      = NUM_CH_DEF,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              resync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

  logic cfg_ok;
  assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < NUM_CH_W);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_ok && (cfg_ch == CH_W'(i));

    clock_enable_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .en_i      (ch_en[i]),
      .resync_i  (resync),
      .wr_i      (wr),
      .div_i     (cfg_div),
      .tick_o    (tick[i]),
      .clk_o     (clk_out[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench: default cadence, shadowed divisor writes, resync, enable gating, out-of-range writes.
module tb_clock_enable_gen;
  import clock_enable_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [3:0]  ch_en;
  logic        resync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  div_t        cfg_div;
  logic [3:0]  tick;
  logic [3:0]  clk_out;
  logic [3:0]  pending;

  // Three-channel instance: a 2-bit index can address a channel that does not exist.
  logic [2:0]  en3;
  logic        we3;
  logic [1:0]  ch3;
  div_t        div3;
  logic [2:0]  tick3;
  logic [2:0]  clk3;
  logic [2:0]  pend3;

  int n;
  int n_chk;
  int n_fail;

  clock_enable_gen dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ch_en   (ch_en),
    .resync  (resync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick),
    .clk_out (clk_out),
    .pending (pending)
  );

  clock_enable_gen #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(4)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .ch_en   (en3),
    .resync  (1'b0),
    .cfg_we  (we3),
    .cfg_ch  (ch3),
    .cfg_div (div3),
    .tick    (tick3),
    .clk_out (clk3),
    .pending (pend3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0] en;
    logic       rs;
    logic       we;
    logic [1:0] ch;
    logic [15:0] div;
    logic [3:0] exp_tick;
    logic [3:0] exp_clk;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[12];

  task automatic cyc();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
  endtask

  initial begin
    n = 0; n_chk = 0; n_fail = 0;
    reset_n = 1'b0; ch_en = '0; resync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    en3 = '0; we3 = 1'b0; ch3 = '0; div3 = '0;

    // State after ch2/ch1 go to D=0/D=5 around a resync; values worked out by hand.
    vecs[0]  = '{4'hf, 1'b0, 1'b1, 2'd2, 16'd0, 4'b0010, 4'b1101, 4'b0100};
    vecs[1]  = '{4'hf, 1'b0, 1'b1, 2'd3, 16'd2, 4'b0001, 4'b1100, 4'b1100};
    vecs[2]  = '{4'hf, 1'b1, 1'b1, 2'd1, 16'd5, 4'b0000, 4'b0000, 4'b0010};
    vecs[3]  = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0100, 4'b0100, 4'b0010};
    vecs[4]  = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b1100, 4'b1000, 4'b0010};
    vecs[5]  = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b1110, 4'b0000};
    vecs[6]  = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b1101, 4'b0011, 4'b0000};
    vecs[7]  = '{4'hf, 1'b0, 1'b1, 2'd2, 16'd1, 4'b0100, 4'b0111, 4'b0100};
    vecs[8]  = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b1100, 4'b1011, 4'b0000};
    vecs[9]  = '{4'hb, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b1011, 4'b0000};
    vecs[10] = '{4'hb, 1'b0, 1'b0, 2'd0, 16'd0, 4'b1011, 4'b0000, 4'b0000};
    vecs[11] = '{4'hf, 1'b0, 1'b0, 2'd0, 16'd0, 4'b0100, 4'b0100, 4'b0000};

    repeat (3) cyc();
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_tick3", 32'(tick3), 32'h0);

    reset_n = 1'b1; ch_en = 4'hf; en3 = 3'h7; n = 0;

    // Default divisor 50 on the main instance, 4 on the small one.
    while (n < 120) begin
      cyc();
      chk("tick_cadence", 32'(tick), (n % 50 == 0) ? 32'hf : 32'h0);
      chk("clk_out_phase", 32'(clk_out), ((n / 50) % 2 == 1) ? 32'hf : 32'h0);
      chk("oor_pending", 32'(pend3), 32'h0);
      chk("oor_tick", 32'(tick3), (n % 4 == 0) ? 32'h7 : 32'h0);
      if (n == 1) begin
        we3 = 1'b1; ch3 = 2'd3; div3 = 16'd1;
      end else begin
        we3 = 1'b0;
      end
    end

    // Mid-period write of D=3 to ch1 waits for the 50-cycle boundary.
    wr(2'd1, 16'd3);
    while (n < 162) begin
      cyc();
      cfg_we = 1'b0;
      chk("ch1_pending", 32'(pending[1]), (n < 150) ? 32'h1 : 32'h0);
      chk("ch1_tick", 32'(tick[1]), (n >= 150 && (n - 150) % 3 == 0) ? 32'h1 : 32'h0);
    end

    // Write lands in the same cycle as ch0 reloads at edge 200.
    while (n < 199) cyc();
    wr(2'd0, 16'd4);
    while (n < 260) begin
      cyc();
      cfg_we = 1'b0;
      chk("ch0_pending", 32'(pending[0]), (n < 250) ? 32'h1 : 32'h0);
      chk("ch0_tick", 32'(tick[0]),
          (n == 200 || n == 250 || (n > 250 && (n - 250) % 4 == 0)) ? 32'h1 : 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      ch_en = vecs[i].en; resync = vecs[i].rs; cfg_we = vecs[i].we;
      cfg_ch = vecs[i].ch; cfg_div = vecs[i].div;
      cyc();
      chk("vec_tick", 32'(tick), 32'(vecs[i].exp_tick));
      chk("vec_clk_out", 32'(clk_out), 32'(vecs[i].exp_clk));
      chk("vec_pending", 32'(pending), 32'(vecs[i].exp_pend));
    end
    ch_en = 4'hf; resync = 1'b0; cfg_we = 1'b0;

    // Equal divisors on all channels, then a resync aligns them.
    for (int c = 0; c < 4; c++) begin
      wr(2'(c), 16'd6);
      cyc();
    end
    cfg_we = 1'b0;
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    chk("resync_tick", 32'(tick), 32'h0);
    chk("resync_clk_out", 32'(clk_out), 32'h0);
    chk("resync_pending", 32'(pending), 32'h0);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      chk("aligned_tick", 32'(tick), (k % 6 == 0) ? 32'hf : 32'h0);
      chk("aligned_clk_out", 32'(clk_out), ((k / 6) % 2 == 1) ? 32'hf : 32'h0);
    end

    // ch3 paused with clk_out high; first tick six edges after re-enable.
    ch_en = 4'b0111;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("dis_tick3", 32'(tick[3]), 32'h0);
      chk("dis_clk3", 32'(clk_out[3]), 32'h1);
    end
    ch_en = 4'hf;
    for (int m = 1; m <= 6; m++) begin
      cyc();
      chk("reen_tick3", 32'(tick[3]), (m == 6) ? 32'h1 : 32'h0);
      chk("reen_clk3", 32'(clk_out[3]), (m == 6) ? 32'h0 : 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
